// File: rtl/alu_seq_pkg.sv
// Shared opcode/state types and constants for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOR = 4'd5,
    OP_LLS = 4'd6,
    OP_LRS = 4'd7,
    OP_ASR = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_MUL = 4'd11
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Bit n set means opcode n is reserved.
  localparam logic [15:0] RSVD_OP_MASK = 16'hF000;

endpackage

// File: rtl/alu_seq_mul.sv
// Sequential shift-add multiplier: accumulator holds {partial, multiplier}
// and retires one multiplier bit per step.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]     psum_s;

  // Step datapath and next-state selection.
  always_comb begin
    psum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_o  = {psum_s, acc_q[WIDTH-1:1]};
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      mcand_d = mcand_i;
      acc_d   = {{WIDTH{1'b0}}, mplier_i};
      cnt_d   = {SHW{1'b0}};
    end else if (step_i) begin
      acc_d = prod_o;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      acc_d = acc_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {SHW{1'b0}};
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: operand registers, single-cycle ops, multi-cycle MUL,
// registered result/flags qualified by a one-cycle done pulse.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  input  logic             lda_i,
  input  logic             ldb_i,
  input  logic             start_i,
  input  logic [3:0]       control_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             neg_o
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, out_q;
  logic               cout_q, zero_q, ovf_q, neg_q, done_q;
  logic [SHW-1:0]     amt_s;
  logic [SHW:0]       ramt_s;
  logic [WIDTH:0]     add_s, sub_s, lls_s, lrs_s, asr_s;
  logic [WIDTH-1:0]   alu_res_s, res_s;
  logic               alu_cout_s, alu_ovf_s, cout_s, ovf_s;
  logic               wr_s, mul_start_s, mul_step_s, mul_last_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  // Single-cycle result and flags; shifts carry out the last bit lost.
  always_comb begin
    amt_s      = b_q[SHW-1:0];
    ramt_s     = (SHW+1)'(WIDTH) - {1'b0, amt_s};
    add_s      = {1'b0, a_q} + {1'b0, b_q};
    sub_s      = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    lls_s      = {1'b0, a_q} << amt_s;
    lrs_s      = {a_q, 1'b0} >> amt_s;
    asr_s      = $unsigned($signed({a_q, 1'b0}) >>> amt_s);
    alu_res_s  = {WIDTH{1'b0}};
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    if (RSVD_OP_MASK[control_i]) begin
      alu_res_s = {WIDTH{1'b0}};
    end else begin
      case (opcode_e'(control_i))
        OP_ADD: begin
          alu_res_s  = add_s[WIDTH-1:0];
          alu_cout_s = add_s[WIDTH];
          alu_ovf_s  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          alu_res_s  = sub_s[WIDTH-1:0];
          alu_cout_s = sub_s[WIDTH];
          alu_ovf_s  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_AND: alu_res_s = a_q & b_q;
        OP_OR:  alu_res_s = a_q | b_q;
        OP_XOR: alu_res_s = a_q ^ b_q;
        OP_NOR: alu_res_s = ~(a_q | b_q);
        OP_LLS: begin
          alu_res_s  = lls_s[WIDTH-1:0];
          alu_cout_s = lls_s[WIDTH];
        end
        OP_LRS: begin
          alu_res_s  = lrs_s[WIDTH:1];
          alu_cout_s = lrs_s[0];
        end
        OP_ASR: begin
          alu_res_s  = asr_s[WIDTH:1];
          alu_cout_s = asr_s[0];
        end
        OP_ROL:  alu_res_s = (a_q << amt_s) | (a_q >> ramt_s);
        OP_ROR:  alu_res_s = (a_q >> amt_s) | (a_q << ramt_s);
        default: alu_res_s = {WIDTH{1'b0}};
      endcase
    end
  end

  // Control FSM: next state, multiplier handshakes and result write select.
  always_comb begin
    state_d     = state_q;
    mul_start_s = 1'b0;
    mul_step_s  = 1'b0;
    wr_s        = 1'b0;
    res_s       = alu_res_s;
    cout_s      = alu_cout_s;
    ovf_s       = alu_ovf_s;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (control_i == OP_MUL)) begin
          mul_start_s = 1'b1;
          state_d     = ST_MUL;
        end else if (start_i) begin
          wr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_step_s = 1'b1;
        if (mul_last_s) begin
          wr_s    = 1'b1;
          res_s   = mul_prod_s[WIDTH-1:0];
          cout_s  = |mul_prod_s[2*WIDTH-1:WIDTH];
          ovf_s   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and output registers; loads are dropped while multiplying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wr_s;
      if (state_q == ST_IDLE && lda_i) a_q <= din_i;
      if (state_q == ST_IDLE && ldb_i) b_q <= din_i;
      if (wr_s) begin
        out_q  <= res_s;
        cout_q <= cout_s;
        ovf_q  <= ovf_s;
        zero_q <= (res_s == {WIDTH{1'b0}});
        neg_q  <= res_s[WIDTH-1];
      end
    end
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_s),
    .step_i   (mul_step_s),
    .mcand_i  (a_q),
    .mplier_i (b_q),
    .last_o   (mul_last_s),
    .prod_o   (mul_prod_s)
  );

  assign busy_o     = (state_q == ST_MUL);
  assign done_o     = done_q;
  assign out_o      = out_q;
  assign cout_o     = cout_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;
  assign neg_o      = neg_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential successor to the 4-bit ALU. Operands load from a shared `din` bus into A/B registers, and a `start` pulse launches one operation. Results and flags are registered and qualified by a one-cycle `done` pulse. The block adds width generalisation, arithmetic shift, rotates, SUB overflow, and a multi-cycle shift-add multiply with a `busy` indication.

## Interface
- `WIDTH`, default 8: datapath width. Must be a power of two, ≥ 4.
- `SHW`, local, = $clog2(WIDTH): shift-amount width. Not overridable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  WIDTH  operand bus shared by A and B.
- `ldA`  in  1  load A from `din` at the edge. Ignored while `busy`.
- `ldB`  in  1  load B from `din` at the edge. Ignored while `busy`.
- `start`  in  1  launch the operation selected by `control`. Ignored while `busy`.
- `control`  in  4  opcode, sampled only at a start edge.
- `busy`  out  1  high while a MUL is iterating.
- `done`  out  1  one-cycle pulse; `out` and flags are valid from this cycle on.
- `out`  out  WIDTH  registered result; held until the next `done`.
- `cout`  out  1  registered carry/status.
- `zero`  out  1  registered flag, `out == 0`.
- `overflow`  out  1  registered signed overflow.
- `neg`  out  1  registered flag, `out[WIDTH-1]`.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 LLS, 7 LRS.
  - 8 ASR, 9 ROL, 10 ROR, 11 MUL.
  - 12–15 reserved.
- Shift and rotate amount is `B[SHW-1:0]`.
- ADD: `out = A+B`; `cout` = carry out; `overflow` = the two operand signs are equal and differ from the result sign.
- SUB: `out = A + ~B + 1`; `cout` = carry out (1 = no borrow); `overflow` = the operand signs differ and the result sign differs from A.
- LLS / LRS / ASR: `cout` = last bit shifted out, 0 when the amount is 0. `overflow` = 0.
- ROL / ROR, logic ops: `cout = 0`, `overflow = 0`.
- MUL: unsigned, `out` = low WIDTH bits of `A*B`; `cout` = 1 if the high WIDTH bits are nonzero; `overflow` = 0.
- Reserved opcodes: `out = 0`, `cout = 0`, `overflow = 0`, `zero = 1`; `done` still pulses.
- `zero` and `neg` are always derived from the final registered `out`.
- FSM states:
  - IDLE: start with a non-MUL opcode → result registered at that edge, stay in IDLE. Start with MUL → latch A, B, clear accumulator, go to MUL, counter = 0.
  - MUL: one shift-add step per cycle. When the counter reaches WIDTH-1, write result and flags, pulse `done`, return to IDLE.
- Simultaneous events:
  - `start` with `ldA`/`ldB` at the same edge uses the pre-edge A/B values.
  - `ldA` and `ldB` together both load the same `din`.
  - `start` or loads during `busy` are dropped with no side effect.

## Timing
- Reset (async assert, sync-released by the caller's domain): `out = 0`, `cout = 0`, `overflow = 0`, `neg = 0`, `zero = 0`, `done = 0`, `busy = 0`, A = B = 0, FSM = IDLE.
- Reset mid-MUL aborts immediately; no `done` is produced.
- Single-cycle ops: start sampled at edge E0 → `out`, flags and `done` update at E0. Latency 1 cycle; back-to-back starts every cycle are allowed.
- MUL: start at E0 → `busy` high after E0. Steps run at E1..E(WIDTH-1) and the final step writes `out`/flags/`done` at E(WIDTH). `busy` low after E(WIDTH). Latency WIDTH cycles.
- A new start is accepted at E(WIDTH+1).
- `done` is never high for two consecutive cycles from the same operation. `out` is stable between `done` pulses.

## Structure
- Package `alu_seq_pkg`:
  - opcode enum (4 bits, values above);
  - FSM state enum {IDLE, MUL};
  - reserved-opcode mask.
- Sub-module `alu_seq_mul`: sequential shift-add multiplier with `start`/`step`/`last` signals and a 2·WIDTH accumulator.
- Single-cycle result and flag logic stays combinational inside `alu_seq`, feeding the output registers.

## Test plan
- WIDTH=8; A=0x7F, B=0x01, ADD → `out = 0x80`, `overflow = 1`, `cout = 0`, `neg = 1`, `zero = 0`, `done` 1 cycle after start.
- SUB with A=0x80, B=0x01 → `out = 0x7F`, `overflow = 1`, `cout = 1`. Then A=0x00, B=0x01 → `out = 0xFF`, `cout = 0`, `overflow = 0`.
- A=0x81, B=0x01:
  - ROL → 0x03, `cout = 0`;
  - ASR → 0xC0, `cout = 1`;
  - LRS → 0x40, `cout = 1`;
  - LLS with B=0 → 0x81, `cout = 0`.
- MUL with A=0x10, B=0x11:
  - `busy` for 8 cycles; `done` at E8;
  - `out = 0x10`, `cout = 1`;
  - `start` and `ldA` (`din` = 0x55) applied mid-MUL are ignored: A still 0x10 and no extra `done`.
- Reset mid-MUL: drop `rst_n` after 3 steps → `busy`, `done`, `out` go to 0 immediately. After release, ADD 0x02+0x03 → `out = 0x05`.
- Same-edge `ldA` (`din` = 0x09) + `start` ADD with A=0x01, B=0x01 → `out = 0x02`. Then `control = 0xF` → `out = 0`, `zero = 1`, `done`.
